decode38_scan: RTL and testbench
================================

DECODE38_SCAN -- requirements
Module: decode38_scan

Interface
REQ-001 Parameter TICK_DIV, default 4, means clock cycles per scan step; legal range 1..255.
REQ-002 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  is the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 Port en  input  1  is the block enable; low forces output inactive.
REQ-005 Port mode  input  1  selects operation: 0 = direct decode, 1 = auto-scan.
REQ-006 Port code_in  input  3  is the code to decode in direct mode.
REQ-007 Port load  input  1  is a single-cycle strobe that captures code_in in direct mode.
REQ-008 Port y  output  8  is the one-hot decoded output, registered; bit k set means index k.
REQ-009 Port idx  output  3  is the binary index currently driven on y, registered.
REQ-010 Port valid  output  1  is high when y holds a decoded value.
REQ-011 Port wrap  output  1  is a one-cycle pulse when the scan index wraps from 7 to 0.

Function
REQ-012 FSM states SHALL be IDLE, DIRECT and SCAN; the state register SHALL be 2 bits.
REQ-013 IDLE -> DIRECT SHALL occur when en=1, mode=0 and load=1; code_in is captured the same edge.
REQ-014 IDLE -> SCAN SHALL occur when en=1 and mode=1; idx starts at 0 and the tick counter clears.
REQ-015 Any state SHALL go to IDLE on the edge where en=0; the next cycle has y=0, valid=0 and wrap=0, and idx holds.
REQ-016 DIRECT with load=1 SHALL capture code_in; y=1<<code_in, idx=code_in and valid=1 appear exactly 1 cycle after the load edge.
REQ-017 DIRECT without load SHALL hold y, idx and valid unchanged.
REQ-018 mode changing while en=1 SHALL switch DIRECT<->SCAN on the next edge; entering SCAN restarts at idx=0, and entering DIRECT holds the last y until the next load.
REQ-019 In SCAN the tick counter SHALL count 0..TICK_DIV-1 and idx SHALL increment when the count equals TICK_DIV-1, so each idx lasts exactly TICK_DIV cycles.
REQ-020 idx SHALL wrap from 7 to 0 mod 8; wrap SHALL be high for exactly the cycle in which idx first shows 0 after 7.
REQ-021 With TICK_DIV=1, idx SHALL advance every cycle and wrap SHALL pulse every 8 cycles.
REQ-022 In SCAN, valid SHALL be 1 from the first cycle after entry.
REQ-023 load in SCAN SHALL be ignored.
REQ-024 y SHALL always be all-zero or exactly one-hot; y SHALL equal 1<<idx whenever valid=1.
REQ-025 If load and en=0 occur on the same edge, en=0 SHALL win and nothing is captured.

Reset
REQ-026 On an rst_n=0 edge: state=IDLE, y=8'h00, idx=3'd0, valid=0, wrap=0, tick counter=0.
REQ-027 Reset SHALL override en, mode and load on the same edge, including mid-scan and mid-load.
REQ-028 The first cycle after rst_n returns high SHALL behave as IDLE.

Structure
REQ-029 State encodings (IDLE=0, DIRECT=1, SCAN=2) SHALL be defined in the shared lab defines header, not locally.
REQ-030 The binary-to-one-hot conversion SHALL be a combinational sub-module decode38_core (in a[2:0], en, out y[7:0]), instantiated once and registered in decode38_scan.
REQ-031 The block SHALL have no latches; all outputs come from flops clocked by clk.

Verification
REQ-032 Reset then en=1, mode=0, load pulse with code_in=5 -> next cycle y=8'b0010_0000, idx=5, valid=1.
REQ-033 en=1, mode=1, TICK_DIV=4, run 32 cycles -> idx steps 0..7, 4 cycles each; wrap pulses once, at the 7->0 step.
REQ-034 Mid-scan at idx=3, drop en for 1 cycle -> y=0, valid=0, idx=3; re-raise en -> scan restarts at idx=0.
REQ-035 Assert rst_n=0 during DIRECT with y=8'h80 -> next cycle y=0, idx=0, valid=0.
REQ-036 Feed y into the team's 8-3 priority encoder with its enable high while sweeping loads 0..7 -> encoder output equals code_in every cycle.
REQ-037 TICK_DIV=1, scan 16 cycles -> y walks 01,02,..,80,01; wrap high on cycles 8 and 16 after entry.

Source files
------------

// File: rtl/decode38_scan_pkg.sv
// Shared definitions for the 3-to-8 decode/scan block: FSM state encodings
// and counter sizing used by decode38_scan.
package decode38_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  // TICK_DIV tops out at 255, so an 8-bit tick counter always suffices.
  localparam int TICK_W = 8;

endpackage

// File: rtl/decode38_core.sv
// Combinational binary-to-one-hot decoder; output is all-zero when disabled.
module decode38_core (
  input  logic [2:0] a,
  input  logic       en,
  output logic [7:0] y
);

  always_comb begin
    y = 8'h00;
    if (en) y[a] = 1'b1;
  end

endmodule

// File: rtl/decode38_scan.sv
// 3-to-8 decoder with direct (load-captured) and auto-scan modes; all
// outputs registered.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | output inactive, waiting for load (direct) or mode=1
//   ST_DIRECT | y/idx hold the last captured code_in, updated on load
//   ST_SCAN   | idx walks 0..7, TICK_DIV cycles per step, wrap on 7->0
module decode38_scan
  import decode38_scan_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode,
  input  logic [2:0] code_in,
  input  logic       load,
  output logic [7:0] y,
  output logic [2:0] idx,
  output logic       valid,
  output logic       wrap
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  state_t            state;
  logic [TICK_W-1:0] tick;
  logic [2:0]        dec_a;
  logic [7:0]        dec_y;

  // The core always decodes whatever index the FSM would load next edge.
  always_comb begin
    dec_a = code_in;
    if (mode) dec_a = (state == ST_SCAN) ? idx + 3'd1 : 3'd0;
  end

  decode38_core u_core (
    .a  (dec_a),
    .en (en),
    .y  (dec_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      y     <= 8'h00;
      idx   <= 3'd0;
      valid <= 1'b0;
      wrap  <= 1'b0;
      tick  <= '0;
    end else if (!en) begin
      state <= ST_IDLE;
      y     <= 8'h00;
      valid <= 1'b0;
      wrap  <= 1'b0;
      tick  <= '0;
    end else begin
      wrap <= 1'b0;
      case (state)
        ST_IDLE, ST_DIRECT: begin
          if (mode) begin
            state <= ST_SCAN;
            idx   <= 3'd0;
            y     <= dec_y;
            valid <= 1'b1;
            tick  <= '0;
          end else if (load) begin
            state <= ST_DIRECT;
            idx   <= code_in;
            y     <= dec_y;
            valid <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (!mode) begin
            // Leaving scan keeps the current y/idx until the next load.
            state <= ST_DIRECT;
          end else if (tick == TICK_LAST) begin
            tick <= '0;
            idx  <= idx + 3'd1;
            y    <= dec_y;
            wrap <= (idx == 3'd7);
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decode38_scan.sv
// Directed scoreboard bench for decode38_scan: TICK_DIV=4 instance for
// direct/scan/reset behaviour, TICK_DIV=1 instance for the fast scan walk.
module tb_decode38_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, mode, load;
  logic       en2, mode2;
  logic [2:0] code_in;

  logic [7:0] y, y2;
  logic [2:0] idx, idx2;
  logic       valid, valid2, wrap, wrap2;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [7:0] y;
    logic [2:0] idx;
    logic       valid;
    logic       wrap;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  decode38_scan #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .code_in(code_in),
    .load(load), .y(y), .idx(idx), .valid(valid), .wrap(wrap)
  );

  decode38_scan #(.TICK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .code_in(code_in),
    .load(load), .y(y2), .idx(idx2), .valid(valid2), .wrap(wrap2)
  );

  function automatic logic [2:0] prienc(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input logic [7:0] ey, input logic [2:0] ei,
                      input logic ev, input logic ew);
    obs_t e;
    e.y = ey; e.idx = ei; e.valid = ev; e.wrap = ew;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic pop_check(input bit fast);
    obs_t  o, e;
    string t;
    o = fast ? {y2, idx2, valid2, wrap2} : {y, idx, valid, wrap};
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed output with no expectation queued");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed y=%h idx=%0d valid=%b wrap=%b, expected y=%h idx=%0d valid=%b wrap=%b",
             t, o.y, o.idx, o.valid, o.wrap, e.y, e.idx, e.valid, e.wrap);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] oh;
    logic [2:0] ei;

    rst_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; code_in = 3'd0;
    en2 = 1'b0; mode2 = 1'b0;

    // Reset state
    step();
    push("reset", 8'h00, 3'd0, 1'b0, 1'b0); step(); pop_check(0);
    push("reset_fast", 8'h00, 3'd0, 1'b0, 1'b0); pop_check(1);
    rst_n = 1'b1;
    push("idle_after_reset", 8'h00, 3'd0, 1'b0, 1'b0); step(); pop_check(0);

    // Direct load of 5, then hold without load
    en = 1'b1; mode = 1'b0; load = 1'b1; code_in = 3'd5;
    push("direct_load5", 8'b0010_0000, 3'd5, 1'b1, 1'b0); step(); pop_check(0);
    load = 1'b0; code_in = 3'd2;
    push("direct_hold", 8'b0010_0000, 3'd5, 1'b1, 1'b0); step(); pop_check(0);

    // Load sweep; output must also round-trip through a priority encoder
    for (int c = 0; c < 8; c++) begin
      load = 1'b1; code_in = 3'(c);
      oh = 8'h01 << c;
      push($sformatf("sweep_load%0d", c), oh, 3'(c), 1'b1, 1'b0);
      step(); pop_check(0);
      vectors++;
      assert (prienc(y) === 3'(c)) else begin
        miscompares++;
        $error("FAIL prienc_%0d: observed %0d expected %0d", c, prienc(y), c);
      end
    end

    // Reset while in DIRECT with y=80 and a load pending
    rst_n = 1'b0; load = 1'b1; code_in = 3'd3;
    push("reset_mid_load", 8'h00, 3'd0, 1'b0, 1'b0); step(); pop_check(0);
    rst_n = 1'b1; load = 1'b0;
    push("idle_no_load", 8'h00, 3'd0, 1'b0, 1'b0); step(); pop_check(0);

    // load together with en=0 captures nothing
    en = 1'b0; load = 1'b1; code_in = 3'd4;
    push("load_en_low", 8'h00, 3'd0, 1'b0, 1'b0); step(); pop_check(0);
    en = 1'b1; load = 1'b0;
    push("load_en_low_after", 8'h00, 3'd0, 1'b0, 1'b0); step(); pop_check(0);

    // Auto-scan with TICK_DIV=4; cycle k counts from the first cycle after entry
    mode = 1'b1;
    for (int k = 0; k <= 44; k++) begin
      load = (k == 10); code_in = 3'd6;
      ei = 3'((k / 4) % 8);
      push($sformatf("scan4_k%0d", k), 8'h01 << ei, ei, 1'b1, (k > 0) && (k % 32 == 0));
      step(); pop_check(0);
    end
    load = 1'b0;

    // Drop en at idx=3, then restart
    en = 1'b0;
    push("scan_en_drop", 8'h00, 3'd3, 1'b0, 1'b0); step(); pop_check(0);
    en = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      ei = 3'((k / 4) % 8);
      push($sformatf("scan_restart_k%0d", k), 8'h01 << ei, ei, 1'b1, 1'b0);
      step(); pop_check(0);
    end

    // SCAN -> DIRECT holds, DIRECT -> SCAN restarts at 0
    mode = 1'b0;
    push("scan_to_direct", 8'h02, 3'd1, 1'b1, 1'b0); step(); pop_check(0);
    push("direct_hold2", 8'h02, 3'd1, 1'b1, 1'b0); step(); pop_check(0);
    mode = 1'b1;
    push("direct_to_scan", 8'h01, 3'd0, 1'b1, 1'b0); step(); pop_check(0);
    en = 1'b0;
    push("scan_off", 8'h00, 3'd0, 1'b0, 1'b0); step(); pop_check(0);

    // TICK_DIV=1 walk
    en2 = 1'b1; mode2 = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      ei = 3'(k % 8);
      push($sformatf("scan1_k%0d", k), 8'h01 << ei, ei, 1'b1, (k > 0) && (k % 8 == 0));
      step(); pop_check(1);
    end

    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_leftover: observed %0d entries, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
